// File: rtl/mem_arb100.sv
// mem_arb100: round-robin arbiter sharing one EN/MFC memory port between fetch (port 0) and load/store (port 1).
// Define MEM_ARB_TIMEOUT_EN to abort an ACCESS after TIMEOUT cycles without MFC (err = 1, rdata = all ones).
module mem_arb100 #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              rw0,
   input  logic              rw1,
   input  logic [DATA_W-1:0] addr0,
   input  logic [DATA_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic [DATA_W-1:0] address,
   output logic [DATA_W-1:0] data_out,
   output logic              RW,
   output logic              EN,
   input  logic              MFC,
   input  logic [DATA_W-1:0] data_in
);

   if (TIMEOUT == 0 || TIMEOUT > 15) begin : g_timeout_range
      $error("mem_arb100: TIMEOUT must lie in 1..15");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              rw_q, rw_d;
   logic              en_q, en_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              win;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [3:0] TMO = 4'(TIMEOUT);
   logic       err_q, err_d;
   logic [3:0] cnt_q, cnt_d, cnt_inc;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         rw_q    <= 1'b1;
         en_q    <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= '0;
         rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         rw_q    <= rw_d;
         en_q    <= en_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         rdata_q <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      rw_d    = rw_q;
      en_d    = en_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      rdata_d = rdata_q;
      // Port 1 wins when alone, or on contention when port 0 won last time.
      win     = req1 & (~req0 | ~last_q);
`ifdef MEM_ARB_TIMEOUT_EN
      err_d   = err_q;
      cnt_d   = cnt_q;
      cnt_inc = cnt_q + 4'd1;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d = ACCESS;
               owner_d = win;
               last_d  = win;
               addr_d  = win ? addr1  : addr0;
               wdat_d  = win ? wdata1 : wdata0;
               rw_d    = win ? rw1    : rw0;
               en_d    = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ACCESS: begin
            if (MFC) begin
               if (rw_q) rdata_d = data_in;
               en_d    = 1'b0;
               ack0_d  = ~owner_q;
               ack1_d  = owner_q;
               state_d = DONE;
`ifdef MEM_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TMO) begin
                  rdata_d = '1;
                  err_d   = 1'b1;
                  en_d    = 1'b0;
                  ack0_d  = ~owner_q;
                  ack1_d  = owner_q;
                  state_d = DONE;
               end
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata    = rdata_q;
   assign address  = addr_q;
   assign data_out = wdat_q;
   assign RW       = rw_q;
   assign EN       = en_q;
`ifdef MEM_ARB_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb100.sv
// Self-checking bench for mem_arb100: bench-side memory responder plus an expected-completion queue.
module tb_mem_arb100;

   typedef struct {
      logic        port;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        rw0 = 1'b1, rw1 = 1'b1;
   logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, err, RW, EN;
   logic [15:0] rdata, address, data_out;
   logic        MFC = 1'b0;
   logic [15:0] data_in = 16'hBAD0;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   logic [15:0] mem [0:255];
   int          mfc_delay = 2;
   logic        mfc_idle = 1'b0;
   int          en_cnt = 0;

   mem_arb100 #(.DATA_W(16), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
      .address(address), .data_out(data_out), .RW(RW), .EN(EN),
      .MFC(MFC), .data_in(data_in)
   );

   always #5 clk = ~clk;

   // Memory: raises MFC in the mfc_delay-th EN cycle (0 = never), else drives mfc_idle.
   always @(posedge clk) begin
      #1;
      if (EN) begin
         en_cnt++;
         if (mfc_delay != 0 && en_cnt >= mfc_delay) begin
            MFC = 1'b1;
            data_in = mem[address[7:0]];
            if (!RW) mem[address[7:0]] = data_out;
         end else begin
            MFC = mfc_idle;
            data_in = 16'hBAD0;
         end
      end else begin
         en_cnt = 0;
         MFC = mfc_idle;
         data_in = 16'hBAD0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1);
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({ack0, ack1, EN, RW, err} !== 5'b00010) begin
         errors++;
         $display("FAIL reset_ctrl: {ack0,ack1,EN,RW,err} got %b expected 00010", {ack0, ack1, EN, RW, err});
      end
      checks++;
      if (address !== 16'h0000) begin
         errors++; $display("FAIL reset_address: got %h expected 0000", address);
      end
      checks++;
      if (data_out !== 16'h0000) begin
         errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out);
      end
      checks++;
      if (rdata !== 16'h0000) begin
         errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata);
      end
   endtask

   task automatic test_read();
      exp_t e;
      int   en_cyc = 0, lat = -1;
      bit   got = 0;
      mem[8'h10] = 16'h1234;
      mfc_delay = 2;
      sb.push_back('{port: 1'b0, rdata: 16'h1234, err: 1'b0});
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'h5A5A;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (EN) en_cyc++;
         if (ack0 || ack1) begin
            got = 1'b1; lat = c;
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL read_unexpected_ack: got ack with empty queue, expected none");
            end else begin
               e = sb.pop_front();
               checks++;
               if ({ack1, ack0} !== {e.port, ~e.port}) begin
                  errors++; $display("FAIL read_port: {ack1,ack0} got %b expected %b", {ack1, ack0}, {e.port, ~e.port});
               end
               checks++;
               if (rdata !== e.rdata) begin
                  errors++; $display("FAIL read_rdata: got %h expected %h", rdata, e.rdata);
               end
               checks++;
               if (err !== e.err) begin
                  errors++; $display("FAIL read_err: got %b expected %b", err, e.err);
               end
            end
         end
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL read_ack_timeout: no ack in 20 cycles, expected ack0");
      end
      checks++;
      if (en_cyc != 2) begin
         errors++; $display("FAIL read_en_cycles: got %0d expected 2", en_cyc);
      end
      checks++;
      if (lat != 3) begin
         errors++; $display("FAIL read_latency: got %0d expected 3", lat);
      end
      @(posedge clk); #1 req0 = 1'b0;
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b0) begin
         errors++; $display("FAIL read_ack_width: ack0 got %b expected 0", ack0);
      end
   endtask

   task automatic test_write();
      exp_t e;
      bit   got = 0;
      int   en_cyc = 0;
      mfc_delay = 3;
      mem[8'h20] = 16'h0000;
      sb.push_back('{port: 1'b1, rdata: 16'h1234, err: 1'b0});
      @(posedge clk); #1;
      req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0020; wdata1 = 16'hBEEF;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (EN) begin
            en_cyc++;
            checks++;
            if ({address, data_out, RW} !== {16'h0020, 16'hBEEF, 1'b0}) begin
               errors++;
               $display("FAIL write_bus: addr/data/RW got %h/%h/%b expected 0020/beef/0", address, data_out, RW);
            end
         end
         if (ack0 || ack1) begin
            got = 1'b1;
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL write_unexpected_ack: got ack with empty queue, expected none");
            end else begin
               e = sb.pop_front();
               checks++;
               if ({ack1, ack0} !== {e.port, ~e.port}) begin
                  errors++; $display("FAIL write_port: {ack1,ack0} got %b expected %b", {ack1, ack0}, {e.port, ~e.port});
               end
               checks++;
               if (rdata !== e.rdata) begin
                  errors++; $display("FAIL write_rdata_hold: got %h expected %h", rdata, e.rdata);
               end
               checks++;
               if (err !== e.err) begin
                  errors++; $display("FAIL write_err: got %b expected %b", err, e.err);
               end
            end
         end
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL write_ack_timeout: no ack in 20 cycles, expected ack1");
      end
      checks++;
      if (en_cyc != 3) begin
         errors++; $display("FAIL write_en_cycles: got %0d expected 3", en_cyc);
      end
      checks++;
      if (mem[8'h20] !== 16'hBEEF) begin
         errors++; $display("FAIL write_mem: got %h expected beef", mem[8'h20]);
      end
      @(posedge clk); #1 req1 = 1'b0; rw1 = 1'b1;
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   n_ack = 0;
      bit   prev_ack = 0;
      mfc_delay = 2;
      mem[8'h30] = 16'hA0A0;
      mem[8'h40] = 16'hB1B1;
      for (int i = 0; i < 4; i++)
         sb.push_back('{port: logic'(i % 2), rdata: (i % 2 != 0) ? 16'hB1B1 : 16'hA0A0, err: 1'b0});
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0030;
      req1 = 1'b1; rw1 = 1'b1; addr1 = 16'h0040;
      for (int c = 0; c < 80 && n_ack < 4; c++) begin
         @(negedge clk);
         if (prev_ack) begin
            checks++;
            if (EN !== 1'b0) begin
               errors++; $display("FAIL rr_idle_gap: EN after ack got %b expected 0", EN);
            end
         end
         prev_ack = ack0 | ack1;
         if (ack0 && ack1) begin
            checks++; errors++;
            $display("FAIL rr_overlap: {ack1,ack0} got 11 expected one-hot");
         end else if (ack0 || ack1) begin
            n_ack++;
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rr_unexpected_ack: got ack with empty queue, expected none");
            end else begin
               e = sb.pop_front();
               checks++;
               if (ack1 !== e.port) begin
                  errors++; $display("FAIL rr_order: grant %0d got port %b expected %b", n_ack, ack1, e.port);
               end
               checks++;
               if (rdata !== e.rdata) begin
                  errors++; $display("FAIL rr_rdata: grant %0d got %h expected %h", n_ack, rdata, e.rdata);
               end
            end
         end
      end
      checks++;
      if (n_ack != 4) begin
         errors++; $display("FAIL rr_count: got %0d acks expected 4", n_ack);
      end
      @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
      sb.delete();
   endtask

   task automatic test_mfc_idle();
      exp_t e;
      int   en_cyc = 0, lat = -1, n_ack = 0;
      mfc_idle = 1'b1;
      mfc_delay = 1;
      mem[8'h50] = 16'h5555;
      repeat (2) @(posedge clk);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({EN, ack0, ack1} !== 3'b000) begin
            errors++; $display("FAIL mfc_idle_ignored: {EN,ack0,ack1} got %b expected 000", {EN, ack0, ack1});
         end
      end
      sb.push_back('{port: 1'b0, rdata: 16'h5555, err: 1'b0});
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0050;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (EN) en_cyc++;
         if (ack0 || ack1) begin
            n_ack++;
            if (lat < 0) lat = c;
            if (c == 2) req0 = 1'b0;
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL mfc_idle_extra_ack: got ack with empty queue, expected single ack0");
            end else begin
               e = sb.pop_front();
               checks++;
               if (rdata !== e.rdata || ack0 !== 1'b1) begin
                  errors++; $display("FAIL mfc_idle_read: rdata/ack0 got %h/%b expected %h/1", rdata, ack0, e.rdata);
               end
            end
         end
         if (c == 2) begin
            @(posedge clk); #1 req0 = 1'b0;
         end
      end
      checks++;
      if (lat != 2 || en_cyc != 1 || n_ack != 1) begin
         errors++;
         $display("FAIL mfc_idle_timing: latency/EN cycles/acks got %0d/%0d/%0d expected 2/1/1", lat, en_cyc, n_ack);
      end
      mfc_idle = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   seen_en = 0, got = 0;
      mfc_delay = 0;
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0060;
      for (int c = 0; c < 10 && !seen_en; c++) begin
         @(negedge clk);
         seen_en = EN;
      end
      checks++;
      if (!seen_en) begin
         errors++; $display("FAIL rstmid_en_rise: EN got 0 expected 1 within 10 cycles");
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({EN, ack0, ack1} !== 3'b000) begin
         errors++; $display("FAIL rstmid_async: {EN,ack0,ack1} got %b expected 000", {EN, ack0, ack1});
      end
      req0 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({EN, ack0, ack1, address} !== {3'b000, 16'h0000}) begin
            errors++;
            $display("FAIL rstmid_no_ack: {EN,ack0,ack1}/address got %b/%h expected 000/0000", {EN, ack0, ack1}, address);
         end
      end
      mfc_delay = 2;
      mem[8'h70] = 16'h7777;
      sb.push_back('{port: 1'b1, rdata: 16'h7777, err: 1'b0});
      @(posedge clk); #1;
      req1 = 1'b1; rw1 = 1'b1; addr1 = 16'h0070;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            got = 1'b1;
            e = sb.pop_front();
            checks++;
            if ({ack1, ack0, rdata} !== {e.port, ~e.port, e.rdata}) begin
               errors++;
               $display("FAIL rstmid_next: {ack1,ack0}/rdata got %b/%h expected %b/%h", {ack1, ack0}, rdata, {e.port, ~e.port}, e.rdata);
            end
         end
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL rstmid_next_timeout: no ack in 20 cycles, expected ack1");
      end
      @(posedge clk); #1 req1 = 1'b0;
      sb.delete();
   endtask

   task automatic test_timeout();
`ifdef MEM_ARB_TIMEOUT_EN
      for (int t = 0; t < 2; t++) begin
         exp_t e;
         int   en_cyc = 0;
         bit   got = 0;
         mfc_delay = (t == 0) ? 0 : 4;
         mem[8'h90] = 16'h9999;
         sb.push_back((t == 0) ? exp_t'('{port: 1'b0, rdata: 16'hFFFF, err: 1'b1})
                               : exp_t'('{port: 1'b0, rdata: 16'h9999, err: 1'b0}));
         @(posedge clk); #1;
         req0 = 1'b1; rw0 = 1'b1; addr0 = (t == 0) ? 16'h0080 : 16'h0090;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (EN) en_cyc++;
            if (ack0 || ack1) begin
               got = 1'b1;
               e = sb.pop_front();
               checks++;
               if ({ack0, rdata, err} !== {1'b1, e.rdata, e.err}) begin
                  errors++;
                  $display("FAIL timeout_%0d: ack0/rdata/err got %b/%h/%b expected 1/%h/%b", t, ack0, rdata, err, e.rdata, e.err);
               end
            end
         end
         checks++;
         if (!got || en_cyc != 4) begin
            errors++; $display("FAIL timeout_%0d_cycles: ack/EN cycles got %b/%0d expected 1/4", t, got, en_cyc);
         end
         @(posedge clk); #1 req0 = 1'b0;
      end
`else
      mfc_delay = 0;
      @(posedge clk); #1;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0080;
      @(negedge clk);
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         checks++;
         if ({EN, ack0, ack1, err} !== 4'b1000) begin
            errors++;
            $display("FAIL hang_cycle_%0d: {EN,ack0,ack1,err} got %b expected 1000", c, {EN, ack0, ack1, err});
         end
      end
      req0 = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
`endif
      sb.delete();
      mfc_delay = 2;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_round_robin();
      test_mfc_idle();
      test_reset_mid();
      test_timeout();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
